// File: rtl/mips_pkg.sv
// mips_pkg: opcodes and instruction-kind enum shared by the decoder and the program loader.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  typedef enum logic [1:0] {KIND_R, KIND_LW, KIND_SW, KIND_ADDI} kind_e;
  function automatic logic [5:0] opcode_of(kind_e k);
    return k == KIND_LW ? OP_LW : k == KIND_SW ? OP_SW : k == KIND_ADDI ? OP_ADDI : OP_RTYPE;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered pointers and occupancy count.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/imem_program_loader.sv
// imem_program_loader: encodes field-level MIPS requests and writes them sequentially into instruction memory.
module imem_program_loader
  import mips_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic [ADDR_W:0]   word_count,
  output logic              done,
  output logic              overflow
);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  function automatic logic [31:0] encode(kind_e k, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                         logic [5:0] funct, logic [15:0] imm);
    return k == KIND_R ? {OP_RTYPE, rs, rt, rd, 5'd0, funct} : {opcode_of(k), rs, rt, imm};
  endfunction
  logic [32:0] head;
  logic full, empty, pop;
  assign in_ready   = !full && !overflow;
  assign imem_we    = !empty && !overflow;
  assign imem_wdata = imem_we ? head[31:0] : '0;
  assign pop        = imem_we && imem_ready;
  sync_fifo #(.WIDTH(33), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid && in_ready),
    .pop   (pop),
    .wdata ({in_last, encode(kind_e'(in_kind), in_rs, in_rt, in_rd, in_funct, in_imm)}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );
  // A non-last word landing on the top address freezes the loader until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_addr  <= BASE;
      word_count <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      done <= pop && head[32];
      if (pop && head[32]) begin
        imem_addr  <= BASE;
        word_count <= '0;
      end else if (pop) begin
        word_count <= word_count + 1'b1;
        if (imem_addr == '1) overflow <= 1'b1;
        else imem_addr <= imem_addr + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_imem_program_loader.sv
// tb_imem_program_loader: directed tests on a default instance and an ADDR_W=2 instance sharing stimulus.
module tb_imem_program_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_last = 1'b0, imem_ready = 1'b1;
  logic [1:0] in_kind = '0;
  logic [4:0] in_rs = '0, in_rt = '0, in_rd = '0;
  logic [5:0] in_funct = '0;
  logic [15:0] in_imm = '0;
  logic a_in_ready, a_imem_we, a_done, a_overflow;
  logic [5:0] a_imem_addr;
  logic [6:0] a_word_count;
  logic [31:0] a_imem_wdata;
  logic b_in_ready, b_imem_we, b_done, b_overflow;
  logic [1:0] b_imem_addr;
  logic [2:0] b_word_count;
  logic [31:0] b_imem_wdata;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] w [5] = '{32'h20000001, 32'h20010002, 32'h20020003, 32'h20030004, 32'h20040005};

  always #5 clk = ~clk;

  imem_program_loader dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct), .in_imm(in_imm),
    .in_last(in_last), .imem_we(a_imem_we), .imem_addr(a_imem_addr), .imem_wdata(a_imem_wdata),
    .imem_ready(imem_ready), .word_count(a_word_count), .done(a_done), .overflow(a_overflow)
  );

  imem_program_loader #(.DEPTH(4), .ADDR_W(2), .BASE_ADDR(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct), .in_imm(in_imm),
    .in_last(in_last), .imem_we(b_imem_we), .imem_addr(b_imem_addr), .imem_wdata(b_imem_wdata),
    .imem_ready(imem_ready), .word_count(b_word_count), .done(b_done), .overflow(b_overflow)
  );

  task automatic set_req(input logic v, input logic [1:0] k, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [5:0] f, input logic [15:0] imm, input logic last);
    in_valid = v; in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_funct = f; in_imm = imm; in_last = last;
  endtask

  task automatic do_reset;
    rst = 1'b1; in_valid = 1'b0; imem_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({a_in_ready, a_imem_we, a_imem_addr, a_imem_wdata, a_word_count, a_done, a_overflow} !==
        {1'b1, 1'b0, 6'd0, 32'd0, 7'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_a: got rdy=%b we=%b addr=%h wd=%h cnt=%h done=%b ovf=%b want 1 0 00 00000000 00 0 0",
               a_in_ready, a_imem_we, a_imem_addr, a_imem_wdata, a_word_count, a_done, a_overflow);
    end
    n_cmp++;
    if ({b_in_ready, b_imem_we, b_imem_addr, b_imem_wdata, b_word_count, b_done, b_overflow} !==
        {1'b1, 1'b0, 2'd0, 32'd0, 3'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_b: got rdy=%b we=%b addr=%h wd=%h cnt=%h done=%b ovf=%b want 1 0 0 00000000 0 0 0",
               b_in_ready, b_imem_we, b_imem_addr, b_imem_wdata, b_word_count, b_done, b_overflow);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_addi;
    do_reset();
    set_req(1'b1, 2'b11, 5'd0, 5'd8, 5'd0, 6'd0, 16'h0005, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if ({a_imem_we, a_imem_addr, a_imem_wdata, a_word_count} !== {1'b1, 6'd0, 32'h20080005, 7'd0}) begin
      n_bad++;
      $display("FAIL addi_write: got we=%b addr=%h wd=%h cnt=%h want 1 00 20080005 00",
               a_imem_we, a_imem_addr, a_imem_wdata, a_word_count);
    end
    @(negedge clk);
    n_cmp++;
    if ({a_done, a_imem_we, a_imem_addr, a_word_count, a_imem_wdata} !== {1'b1, 1'b0, 6'd0, 7'd0, 32'd0}) begin
      n_bad++;
      $display("FAIL addi_done: got done=%b we=%b addr=%h cnt=%h wd=%h want 1 0 00 00 00000000",
               a_done, a_imem_we, a_imem_addr, a_word_count, a_imem_wdata);
    end
    @(negedge clk);
    n_cmp++;
    if (a_done !== 1'b0) begin
      n_bad++;
      $display("FAIL addi_done_pulse: got done=%b want 0", a_done);
    end
  endtask

  task automatic test_rtype_lw;
    do_reset();
    set_req(1'b1, 2'b00, 5'd9, 5'd10, 5'd8, 6'h20, 16'h0000, 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({a_imem_we, a_imem_addr, a_imem_wdata, a_word_count} !== {1'b1, 6'd0, 32'h012A4020, 7'd0}) begin
      n_bad++;
      $display("FAIL rtype_write: got we=%b addr=%h wd=%h cnt=%h want 1 00 012a4020 00",
               a_imem_we, a_imem_addr, a_imem_wdata, a_word_count);
    end
    set_req(1'b1, 2'b01, 5'd29, 5'd8, 5'd0, 6'd0, 16'h0004, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if ({a_imem_we, a_imem_addr, a_imem_wdata, a_word_count} !== {1'b1, 6'd1, 32'h8FA80004, 7'd1}) begin
      n_bad++;
      $display("FAIL lw_write: got we=%b addr=%h wd=%h cnt=%h want 1 01 8fa80004 01",
               a_imem_we, a_imem_addr, a_imem_wdata, a_word_count);
    end
    @(negedge clk);
    n_cmp++;
    if ({a_done, a_imem_we, a_imem_addr, a_word_count} !== {1'b1, 1'b0, 6'd0, 7'd0}) begin
      n_bad++;
      $display("FAIL rtype_lw_done: got done=%b we=%b addr=%h cnt=%h want 1 0 00 00",
               a_done, a_imem_we, a_imem_addr, a_word_count);
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 2'b11, 5'd0, 5'(i), 5'd0, 6'd0, 16'(i + 1), 1'b0);
      n_cmp++;
      if (a_in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL bp_accept%0d: got in_ready=%b want 1", i, a_in_ready);
      end
      @(negedge clk);
    end
    set_req(1'b1, 2'b11, 5'd0, 5'd4, 5'd0, 6'd0, 16'd5, 1'b1);
    for (int s = 0; s < 2; s++) begin
      n_cmp++;
      if ({a_in_ready, a_imem_we, a_imem_addr, a_imem_wdata} !== {1'b0, 1'b1, 6'd0, w[0]}) begin
        n_bad++;
        $display("FAIL bp_stall%0d: got rdy=%b we=%b addr=%h wd=%h want 0 1 00 %h",
                 s, a_in_ready, a_imem_we, a_imem_addr, a_imem_wdata, w[0]);
      end
      if (s == 0) @(negedge clk);
    end
    imem_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({a_in_ready, a_imem_addr, a_imem_wdata} !== {1'b1, 6'd1, w[1]}) begin
      n_bad++;
      $display("FAIL bp_release: got rdy=%b addr=%h wd=%h want 1 01 %h", a_in_ready, a_imem_addr, a_imem_wdata, w[1]);
    end
    for (int k = 2; k < 5; k++) begin
      @(negedge clk);
      if (k == 2) in_valid = 1'b0;
      n_cmp++;
      if ({a_imem_we, a_imem_addr, a_imem_wdata} !== {1'b1, 6'(k), w[k]}) begin
        n_bad++;
        $display("FAIL bp_word%0d: got we=%b addr=%h wd=%h want 1 %h %h", k, a_imem_we, a_imem_addr, a_imem_wdata, 6'(k), w[k]);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({a_done, a_imem_addr, a_word_count, a_imem_we} !== {1'b1, 6'd0, 7'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL bp_done: got done=%b addr=%h cnt=%h we=%b want 1 00 00 0", a_done, a_imem_addr, a_word_count, a_imem_we);
    end
  endtask

  task automatic test_sw_unused;
    do_reset();
    set_req(1'b1, 2'b10, 5'd29, 5'd9, 5'd31, 6'h3F, 16'hFFFC, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if ({a_imem_we, a_imem_wdata} !== {1'b1, 32'hAFA9FFFC}) begin
      n_bad++;
      $display("FAIL sw_encode: got we=%b wd=%h want 1 afa9fffc", a_imem_we, a_imem_wdata);
    end
    @(negedge clk);
    n_cmp++;
    if (a_done !== 1'b1) begin
      n_bad++;
      $display("FAIL sw_done: got done=%b want 1", a_done);
    end
  endtask

  task automatic test_top_last;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 2'b11, 5'd0, 5'(i), 5'd0, 6'd0, 16'(i + 1), i == 3);
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_cmp++;
    if ({b_imem_we, b_imem_addr, b_imem_wdata} !== {1'b1, 2'd3, w[3]}) begin
      n_bad++;
      $display("FAIL top_last_write: got we=%b addr=%h wd=%h want 1 3 %h", b_imem_we, b_imem_addr, b_imem_wdata, w[3]);
    end
    @(negedge clk);
    n_cmp++;
    if ({b_done, b_overflow, b_imem_addr, b_word_count, b_in_ready} !== {1'b1, 1'b0, 2'd0, 3'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL top_last_done: got done=%b ovf=%b addr=%h cnt=%h rdy=%b want 1 0 0 0 1",
               b_done, b_overflow, b_imem_addr, b_word_count, b_in_ready);
    end
  endtask

  task automatic test_overflow;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_req(1'b1, 2'b11, 5'd0, 5'(i), 5'd0, 6'd0, 16'(i + 1), 1'b0);
      n_cmp++;
      if (b_in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL ovf_accept%0d: got in_ready=%b want 1", i, b_in_ready);
      end
      if (i > 0) begin
        n_cmp++;
        if ({b_imem_we, b_imem_addr, b_imem_wdata} !== {1'b1, 2'(i - 1), w[i-1]}) begin
          n_bad++;
          $display("FAIL ovf_word%0d: got we=%b addr=%h wd=%h want 1 %h %h",
                   i - 1, b_imem_we, b_imem_addr, b_imem_wdata, 2'(i - 1), w[i-1]);
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      n_cmp++;
      if ({b_overflow, b_imem_we, b_in_ready, b_imem_addr, b_imem_wdata, b_word_count, dut_b.u_fifo.count} !==
          {1'b1, 1'b0, 1'b0, 2'd3, 32'd0, 3'd4, 3'd1}) begin
        n_bad++;
        $display("FAIL ovf_hold%0d: got ovf=%b we=%b rdy=%b addr=%h wd=%h cnt=%h fifo=%h want 1 0 0 3 00000000 4 1",
                 s, b_overflow, b_imem_we, b_in_ready, b_imem_addr, b_imem_wdata, b_word_count, dut_b.u_fifo.count);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({b_overflow, b_imem_we, b_in_ready, b_imem_addr, b_word_count, b_done} !== {1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL ovf_clear: got ovf=%b we=%b rdy=%b addr=%h cnt=%h done=%b want 0 0 1 0 0 0",
               b_overflow, b_imem_we, b_in_ready, b_imem_addr, b_word_count, b_done);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 2'b11, 5'd0, 5'(i), 5'd0, 6'd0, 16'(i + 1), i == 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_cmp++;
    if ({a_imem_we, a_imem_wdata} !== {1'b1, w[0]}) begin
      n_bad++;
      $display("FAIL mid_queued: got we=%b wd=%h want 1 %h", a_imem_we, a_imem_wdata, w[0]);
    end
    imem_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({a_in_ready, a_imem_we, a_imem_addr, a_imem_wdata, a_word_count, a_done, a_overflow} !==
        {1'b1, 1'b0, 6'd0, 32'd0, 7'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL mid_reset: got rdy=%b we=%b addr=%h wd=%h cnt=%h done=%b ovf=%b want 1 0 00 00000000 00 0 0",
               a_in_ready, a_imem_we, a_imem_addr, a_imem_wdata, a_word_count, a_done, a_overflow);
    end
    @(negedge clk);
    n_cmp++;
    if ({a_done, a_imem_we, a_in_ready} !== {1'b0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL mid_after: got done=%b we=%b rdy=%b want 0 0 1", a_done, a_imem_we, a_in_ready);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_addi();
    test_rtype_lw();
    test_back_to_back();
    test_sw_unused();
    test_top_last();
    test_overflow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
